tx: RTL and testbench

Asynchronous serial transmitter, the counterpart of the existing rx block. It accepts a parallel byte through a valid/ready handshake and shifts out one 8N1 frame on tx_so: start bit 0, 8 data bits LSB first, stop bit 1. Bit timing is CLKS_PER_BIT clocks per bit, matching rx. A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/tx_pkg.sv | 17 +
 rtl/tx_if.sv | 22 ++
 rtl/tx_baud_cnt.sv | 28 ++
 rtl/tx.sv | 124 ++++++++++++
 tb/tb_tx.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/tx_pkg.sv
// Shared UART definitions: line levels, frame defaults and transmitter states.
package tx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 8;
  localparam int unsigned DATA_W_DEF       = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_if.sv
// Parallel byte handshake into the serial transmitter.
interface tx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_pi;
  logic              tx_data_valid;
  logic              tx_ready;

  modport master (
    output tx_pi,
    output tx_data_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_pi,
    input  tx_data_valid,
    output tx_ready
  );

endinterface

// File: rtl/tx_baud_cnt.sv
// Divide-by-CLKS_PER_BIT bit timer with synchronous clear; bit_end marks the last clock of a bit.
module tx_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned         CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = ~clear & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx.sv
// 8N1 serial transmitter with a one-entry holding register for gapless back-to-back frames.
module tx
  import tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  tx_if.slave  bus,
  output logic tx_so,
  output logic tx_busy,
  output logic tx_done
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state, state_next;
  logic              hold_full, hold_full_next;
  logic [DATA_W-1:0] hold, hold_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic              so_next, done_next;
  logic              accept, bit_end, baud_clear, load_frame;

  assign bus.tx_ready = en & ~hold_full;
  assign accept       = bus.tx_data_valid & bus.tx_ready;
  assign tx_busy      = (state != ST_IDLE);
  assign baud_clear   = (state == ST_IDLE);

  tx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  always_comb begin
    state_next     = state;
    shift_next     = shift;
    bit_cnt_next   = bit_cnt;
    so_next        = tx_so;
    done_next      = 1'b0;
    load_frame     = 1'b0;
    hold_next      = hold;
    hold_full_next = hold_full;

    case (state)
      ST_IDLE: begin
        if (en && hold_full) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          so_next    = shift[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_next   = ST_STOP;
            so_next      = STOP_BIT;
            bit_cnt_next = '0;
          end else begin
            shift_next   = shift >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
            so_next      = shift_next[0];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done_next = 1'b1;
          if (en && hold_full) begin
            load_frame = 1'b1;
          end else begin
            state_next = ST_IDLE;
            so_next    = STOP_BIT;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Shared by IDLE and end-of-stop so chained frames start without an idle cycle.
    if (load_frame) begin
      state_next     = ST_START;
      shift_next     = hold;
      bit_cnt_next   = '0;
      so_next        = START_BIT;
      hold_full_next = 1'b0;
    end

    // Acceptance needs hold_full==0 pre-edge, so it never collides with a transfer.
    if (accept) begin
      hold_full_next = 1'b1;
      hold_next      = bus.tx_pi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      hold      <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      tx_so     <= STOP_BIT;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_next;
      hold_full <= hold_full_next;
      hold      <= hold_next;
      shift     <= shift_next;
      bit_cnt   <= bit_cnt_next;
      tx_so     <= so_next;
      tx_done   <= done_next;
    end
  end

endmodule

// File: tb/tb_tx.sv
// Bench for tx: frame-timeline reference model compared against the line every clock.
module tb_tx;
  import tx_pkg::*;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned FRAME = (DW + 2) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic tx_so, tx_busy, tx_done;

  tx_if #(.DATA_W(DW)) bus ();

  tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bus     (bus.slave),
    .tx_so   (tx_so),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a frame is a byte plus the number of clocks since it began.
  logic          m_hold_full;
  logic [DW-1:0] m_hold;
  logic          m_active;
  logic [DW-1:0] m_byte;
  int            m_elapsed;
  logic          m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_line();
    int b;
    if (!m_active) return 1'b1;
    b = m_elapsed / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_hold_full = 1'b0;
    m_hold      = '0;
    m_active    = 1'b0;
    m_byte      = '0;
    m_elapsed   = 0;
    m_done      = 1'b0;
  endtask

  task automatic model_edge(output logic acc);
    acc    = bus.tx_data_valid && en && !m_hold_full;
    m_done = 1'b0;
    if (m_active) begin
      m_elapsed++;
      if (m_elapsed == FRAME) begin
        m_done   = 1'b1;
        m_active = 1'b0;
      end
    end
    if (!m_active && en && m_hold_full) begin
      m_active    = 1'b1;
      m_byte      = m_hold;
      m_elapsed   = 0;
      m_hold_full = 1'b0;
    end
    if (acc) begin
      m_hold_full = 1'b1;
      m_hold      = bus.tx_pi;
    end
  endtask

  // Called at a falling edge; returns whether the byte was accepted on the next rising edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic e, output logic acc);
    bus.tx_data_valid = v;
    bus.tx_pi         = d;
    en                = e;
    #1;
    check("ready", bus.tx_ready, e & ~m_hold_full);
    model_edge(acc);
    @(posedge clk);
    @(negedge clk);
    check("so", tx_so, exp_line());
    check("busy", tx_busy, m_active);
    check("done", tx_done, m_done);
  endtask

  task automatic run(input int n, input logic e);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, DW'($urandom), e, acc);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic e);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) cycle(1'b1, d, e, acc);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    bus.tx_data_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    bus.tx_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_so", tx_so, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic acc_r;
  int   spin;

  initial begin
    model_reset();
    bus.tx_data_valid = 1'b0;
    bus.tx_pi         = '0;
    en                = 1'b1;
    repeat (3) @(negedge clk);
    check("init_so", tx_so, 1'b1);
    check("init_busy", tx_busy, 1'b0);
    check("init_done", tx_done, 1'b0);
    rst_n = 1'b1;
    #1;
    check("init_ready", bus.tx_ready, 1'b1);

    // Single byte, then back-to-back pair offered as soon as ready rises.
    send(8'hA5, 1'b1);
    run(FRAME + 4, 1'b1);
    send(8'h55, 1'b1);
    send(8'h33, 1'b1);
    run(2 * FRAME + 4, 1'b1);

    // Offer while the holding register is full: ignored.
    send(8'h22, 1'b1);
    send(8'hAA, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h11, 1'b1, acc_r);
    run(2 * FRAME + 4, 1'b1);

    // Enable drops mid-frame with a byte held.
    send(8'hF0, 1'b1);
    send(8'h0F, 1'b1);
    run(20, 1'b1);
    run(FRAME + 40, 1'b0);
    run(FRAME + 4, 1'b1);

    // Reset during data bit 3.
    send(8'h81, 1'b1);
    send(8'h7E, 1'b1);
    spin = 0;
    while (m_elapsed < 4 * CPB + 3 && spin < 200) begin
      run(1, 1'b1);
      spin++;
    end
    reset_pulse();
    run(FRAME + 4, 1'b1);

    // Boundary bytes.
    send(8'h00, 1'b1);
    run(FRAME + 4, 1'b1);
    send(8'hFF, 1'b1);
    run(FRAME + 4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 9) < 3), DW'($urandom), ($urandom_range(0, 19) != 0), acc_r);
    run(2 * FRAME + 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
